// File: rtl/seven_seg_if.sv
// Bus between the digit source/board side and the seven-segment scan controller.
// SEVSEG_BRIGHTNESS_EN adds the 3-bit brightness input.
interface seven_seg_if;
   logic       enable;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic [3:0] digit3;
   logic [3:0] blank;
`ifdef SEVSEG_BRIGHTNESS_EN
   logic [2:0] brightness;
`endif
   logic [3:0] anode;
   logic [1:0] sel;
   logic [3:0] digit_val;
   logic       frame_start;

   modport master (
`ifdef SEVSEG_BRIGHTNESS_EN
      output brightness,
`endif
      output enable, digit0, digit1, digit2, digit3, blank,
      input  anode, sel, digit_val, frame_start
   );

   modport slave (
`ifdef SEVSEG_BRIGHTNESS_EN
      input  brightness,
`endif
      input  enable, digit0, digit1, digit2, digit3, blank,
      output anode, sel, digit_val, frame_start
   );
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode scan controller with per-frame digit snapshot.
// SEVSEG_BRIGHTNESS_EN enables PWM dimming of the anode within each digit slot.
module seven_seg_scanner #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned CNT_W       = 17
) (
   input logic        clk,
   input logic        rst_n,
   seven_seg_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
`ifdef SEVSEG_BRIGHTNESS_EN
   localparam int unsigned THR_W = CNT_W + 4;
`endif

   typedef enum logic {ST_IDLE, ST_SCAN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       sel_q, sel_d;
   logic [3:0][3:0]  snap_q, snap_d;
   logic [3:0]       anode_q, anode_d;
   logic [3:0]       digit_val_q, digit_val_d;
   logic             frame_start_q, frame_start_d;
   logic             new_frame;
   logic             lit;
`ifdef SEVSEG_BRIGHTNESS_EN
   logic [2:0]       bright_q, bright_d;
   logic [THR_W-1:0] thr;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         sel_q         <= '0;
         snap_q        <= '0;
         anode_q       <= 4'b1111;
         digit_val_q   <= '0;
         frame_start_q <= 1'b0;
`ifdef SEVSEG_BRIGHTNESS_EN
         bright_q      <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sel_q         <= sel_d;
         snap_q        <= snap_d;
         anode_q       <= anode_d;
         digit_val_q   <= digit_val_d;
         frame_start_q <= frame_start_d;
`ifdef SEVSEG_BRIGHTNESS_EN
         bright_q      <= bright_d;
`endif
      end
   end

   // Outputs are computed from the next-cycle sel/counter so anode, sel and digit_val switch together.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      sel_d         = sel_q;
      snap_d        = snap_q;
      anode_d       = 4'b1111;
      digit_val_d   = digit_val_q;
      frame_start_d = 1'b0;
      new_frame     = 1'b0;
      lit           = 1'b0;
`ifdef SEVSEG_BRIGHTNESS_EN
      bright_d      = bright_q;
      thr           = '0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.enable) begin
               state_d   = ST_SCAN;
               cnt_d     = '0;
               sel_d     = 2'd0;
               new_frame = 1'b1;
            end
         end
         ST_SCAN: begin
            if (!bus.enable) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               sel_d   = 2'd0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               sel_d     = sel_q + 2'd1;
               new_frame = (sel_q == 2'd3);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (new_frame) begin
         snap_d        = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
         frame_start_d = 1'b1;
`ifdef SEVSEG_BRIGHTNESS_EN
         bright_d      = bus.brightness;
`endif
      end

      if (state_d == ST_SCAN) begin
         digit_val_d = snap_d[sel_d];
`ifdef SEVSEG_BRIGHTNESS_EN
         thr = ((THR_W'(bright_d) + THR_W'(1)) * THR_W'(REFRESH_DIV)) >> 3;
         lit = !bus.blank[sel_d] && ({4'b0000, cnt_d} < thr);
`else
         lit = !bus.blank[sel_d];
`endif
         if (lit) anode_d = ~(4'b0001 << sel_d);
      end
   end

   assign bus.anode       = anode_q;
   assign bus.sel         = sel_q;
   assign bus.digit_val   = digit_val_q;
   assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: time-based reference model checked every cycle plus directed checks.
module tb_seven_seg_scanner;
`ifdef SEVSEG_BRIGHTNESS_EN
   localparam int unsigned R = 8;
`else
   localparam int unsigned R = 4;
`endif
   localparam int unsigned FRAME = 4 * R;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   seven_seg_if bus ();

   seven_seg_scanner #(.REFRESH_DIV(R), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: m_t is the cycle index since the latest fresh start of scanning.
   logic            m_run;
   int              m_t;
   logic [3:0][3:0] m_snap;
   logic [3:0]      m_blank;
   int              m_bright;

   function automatic int next_t();
      return m_run ? m_t + 1 : 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run    <= 1'b0;
         m_t      <= 0;
         m_snap   <= '0;
         m_blank  <= '0;
         m_bright <= 7;
      end else if (!bus.enable) begin
         m_run <= 1'b0;
      end else begin
         m_run   <= 1'b1;
         m_t     <= next_t();
         m_blank <= bus.blank;
         if (next_t() % FRAME == 0) begin
            m_snap <= {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
`ifdef SEVSEG_BRIGHTNESS_EN
            m_bright <= int'(bus.brightness);
`endif
         end
      end
   end

   function automatic int exp_sel();
      return m_run ? (m_t / R) % 4 : 0;
   endfunction

   function automatic int exp_anode();
      int s;
      int thr;
      if (!m_run) return 15;
      s   = exp_sel();
      thr = ((m_bright + 1) * R) / 8;
      if (m_blank[s] || (m_t % R) >= thr) return 15;
      return 15 - (1 << s);
   endfunction

   // While dark, digit_val holds whatever slot was last shown.
   function automatic int exp_dv();
      return int'(m_snap[(m_t / R) % 4]);
   endfunction

   function automatic int exp_fs();
      return (m_run && (m_t % FRAME == 0)) ? 1 : 0;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         check("model_anode", int'(bus.anode), exp_anode());
         check("model_sel", int'(bus.sel), exp_sel());
         check("model_digit_val", int'(bus.digit_val), exp_dv());
         check("model_frame_start", int'(bus.frame_start), exp_fs());
      end
   end

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_fs();
      int n = 0;
      while (bus.frame_start !== 1'b1 && n < 5 * FRAME) begin
         adv(1);
         n++;
      end
      check("frame_start_timeout", int'(bus.frame_start), 1);
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.enable = 1'b0;
      bus.digit0 = 4'd0;
      bus.digit1 = 4'd1;
      bus.digit2 = 4'd2;
      bus.digit3 = 4'd3;
      bus.blank  = 4'b0000;
`ifdef SEVSEG_BRIGHTNESS_EN
      bus.brightness = 3'd7;
`endif
      repeat (3) @(negedge clk);
      check("rst_anode", int'(bus.anode), 4'hF);
      check("rst_sel", int'(bus.sel), 0);
      check("rst_digit_val", int'(bus.digit_val), 0);
      check("rst_frame_start", int'(bus.frame_start), 0);
      rst_n = 1'b1;
      @(negedge clk);
      bus.enable = 1'b1;

      // Basic scan order and first frame start
      adv(1);
      check("first_fs", int'(bus.frame_start), 1);
      check("first_anode", int'(bus.anode), 4'b1110);
      check("first_dv", int'(bus.digit_val), 0);
      for (int k = 1; k <= int'(FRAME); k++) begin
         adv(1);
         if (k == int'(R)) begin
            check("slot1_anode", int'(bus.anode), 4'b1101);
            check("slot1_dv", int'(bus.digit_val), 1);
            check("slot1_fs", int'(bus.frame_start), 0);
         end
         if (k == int'(2 * R)) check("slot2_anode", int'(bus.anode), 4'b1011);
         if (k == int'(3 * R)) begin
            check("slot3_anode", int'(bus.anode), 4'b0111);
            check("slot3_dv", int'(bus.digit_val), 3);
         end
         if (k == int'(FRAME)) begin
            check("wrap_fs", int'(bus.frame_start), 1);
            check("wrap_anode", int'(bus.anode), 4'b1110);
         end
      end

      // Mid-frame digit change is deferred to the next frame
      adv(2 * R);
      check("mid_sel2", int'(bus.sel), 2);
      bus.digit1 = 4'd9;
      adv(2 * R);
      check("next_frame_dv0", int'(bus.digit_val), 0);
      adv(R);
      check("next_frame_dv1", int'(bus.digit_val), 9);

      // Live blanking of slot 2
      bus.blank = 4'b0100;
      adv(R);
      check("blank_sel", int'(bus.sel), 2);
      check("blank_anode", int'(bus.anode), 4'hF);
      adv(R);
      check("after_blank_anode", int'(bus.anode), 4'b0111);
      bus.blank = 4'b0000;

      // Drop enable mid-slot, then re-enable
      adv(3 * R + 1);
      check("pre_dis_sel", int'(bus.sel), 2);
      bus.enable = 1'b0;
      adv(1);
      check("dis_anode", int'(bus.anode), 4'hF);
      check("dis_sel", int'(bus.sel), 0);
      check("dis_dv_hold", int'(bus.digit_val), 2);
      bus.digit0 = 4'd5;
      adv(3);
      bus.enable = 1'b1;
      adv(1);
      check("reen_fs", int'(bus.frame_start), 1);
      check("reen_anode", int'(bus.anode), 4'b1110);
      check("reen_dv", int'(bus.digit_val), 5);

      // Asynchronous reset mid-slot
      adv(R + 1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_anode", int'(bus.anode), 4'hF);
      check("arst_sel", int'(bus.sel), 0);
      check("arst_dv", int'(bus.digit_val), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      adv(1);
      check("post_rst_fs", int'(bus.frame_start), 1);
      check("post_rst_anode", int'(bus.anode), 4'b1110);
      check("post_rst_dv", int'(bus.digit_val), 5);

`ifdef SEVSEG_BRIGHTNESS_EN
      // Brightness duty: active cycles per frame = 4 * ((b+1)*R >> 3)
      begin
         int lit_cnt;
         bus.brightness = 3'd1;
         adv(1);
         wait_fs();
         lit_cnt = 0;
         for (int i = 0; i < int'(FRAME); i++) begin
            if (bus.anode != 4'hF) lit_cnt++;
            adv(1);
         end
         check("bright1_lit", lit_cnt, 8);
         bus.brightness = 3'd7;
         adv(1);
         wait_fs();
         lit_cnt = 0;
         for (int i = 0; i < int'(FRAME); i++) begin
            if (bus.anode != 4'hF) lit_cnt++;
            adv(1);
         end
         check("bright7_lit", lit_cnt, 32);
      end
`else
      adv(1);
      wait_fs();
`endif

      adv(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
